ddr_capture_pipe: RTL and testbench

//  Parametrised dual-edge capture stage. Samples a WIDTH-bit bus on both clock edges through

---
 rtl/ddr_capture_pipe.sv | 118 +++++++++++
 tb/tb_ddr_capture_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_capture_pipe.sv
`default_nettype none
// ============================================================================
// Module  : ddr_capture_pipe
// Brief   : Dual-edge capture pipes, DDR rebuild on q and posedge pair packing.
// Revision: 1.0 - initial release
// ============================================================================
module ddr_capture_pipe #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               ddr_mode,
    input  logic [WIDTH-1:0]   d,
    output logic [WIDTH-1:0]   q,
    output logic [2*WIDTH-1:0] word,
    output logic               word_valid,
    output logic [CNT_W-1:0]   pair_cnt
);

    localparam int              FILL_W  = $clog2(DEPTH + 1);
    localparam logic [FILL_W:0] DEPTH_C = (FILL_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_pipe_q [DEPTH];
    logic [WIDTH-1:0]   f_pipe_q [DEPTH];
    logic               en_q;
    logic               mode_q;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    logic [2*WIDTH-1:0] word_q;
    logic [2*WIDTH-1:0] word_d;
    logic               word_valid_q;
    logic               word_valid_d;
    logic [CNT_W-1:0]   pair_cnt_q;
    logic [CNT_W-1:0]   pair_cnt_d;

    logic [WIDTH-1:0]   w_r_last;
    logic [WIDTH-1:0]   w_f_last;
    logic [FILL_W:0]    w_fill_inc;
    logic               w_pair_done;
    logic               w_mode_chg;

    assign w_r_last    = r_pipe_q[DEPTH-1];
    assign w_f_last    = f_pipe_q[DEPTH-1];
    assign w_pair_done = mode_q & en_q;
    assign w_mode_chg  = ddr_mode ^ mode_q;
    assign w_fill_inc  = {1'b0, fill_q} + (FILL_W + 1)'(1);

    // A pair is the rise sample of the previous posedge plus the fall sample in between;
    // both last stages still hold it here because the shift happens on this same edge.
    always_comb begin
        fill_d       = fill_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        pair_cnt_d   = pair_cnt_q;
        if (w_pair_done) begin
            word_d       = {w_f_last, w_r_last};
            pair_cnt_d   = pair_cnt_q + CNT_W'(1);
            fill_d       = (w_fill_inc >= DEPTH_C) ? DEPTH_C[FILL_W-1:0] : w_fill_inc[FILL_W-1:0];
            word_valid_d = (w_fill_inc >= DEPTH_C);
        end
        if (w_mode_chg) begin
            fill_d       = '0;
            word_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe_q[i] <= RST_VAL;
            end
            en_q         <= 1'b0;
            mode_q       <= 1'b0;
            fill_q       <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            pair_cnt_q   <= '0;
        end else begin
            en_q         <= en;
            mode_q       <= ddr_mode;
            fill_q       <= fill_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            pair_cnt_q   <= pair_cnt_d;
            if (en) begin
                r_pipe_q[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    r_pipe_q[i] <= r_pipe_q[i-1];
                end
            end
        end
    end

    // Gated by the posedge-registered enables so each fall capture pairs with the rise before it.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                f_pipe_q[i] <= RST_VAL;
            end
        end else if (mode_q && en_q) begin
            f_pipe_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                f_pipe_q[i] <= f_pipe_q[i-1];
            end
        end
    end

    assign q          = (mode_q && !clk) ? w_f_last : w_r_last;
    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign pair_cnt   = pair_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_capture_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_ddr_capture_pipe
// Brief   : Three parameter sets of ddr_capture_pipe driven together against a history model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ddr_capture_pipe;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        ddr_mode;
    logic [7:0]  d;
    logic [7:0]  q0, q1, q2;
    logic [15:0] w0, w1, w2;
    logic        v0, v1, v2;
    logic [15:0] c0, c1;
    logic [3:0]  c2;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    ddr_capture_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .ddr_mode(ddr_mode), .d(d),
        .q(q0), .word(w0), .word_valid(v0), .pair_cnt(c0));
    ddr_capture_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hA5), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .ddr_mode(ddr_mode), .d(d),
        .q(q1), .word(w1), .word_valid(v1), .pair_cnt(c1));
    ddr_capture_pipe #(.WIDTH(8), .DEPTH(2), .RST_VAL(8'h3C), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .ddr_mode(ddr_mode), .d(d),
        .q(q2), .word(w2), .word_valid(v2), .pair_cnt(c2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

    // Model: full capture histories since reset; a last stage is the sample captured DEPTH
    // captures ago, or the reset value if fewer captures have happened.
    logic [7:0]  rh[$];
    logic [7:0]  fh[$];
    logic        m_en_q;
    logic        m_mode_q;
    int          m_fill  [3];
    logic [15:0] m_word  [3];
    logic        m_valid [3];
    int unsigned m_cnt   [3];

    function automatic int dep(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [7:0] rv(input int i);
        case (i)
            0:       return 8'h00;
            1:       return 8'hA5;
            default: return 8'h3C;
        endcase
    endfunction

    function automatic logic [31:0] cnt_mask(input int i);
        return (i == 2) ? 32'h0000_000F : 32'h0000_FFFF;
    endfunction

    function automatic logic [7:0] r_last(input int i);
        if (rh.size() < dep(i)) return rv(i);
        return rh[rh.size() - dep(i)];
    endfunction

    function automatic logic [7:0] f_last(input int i);
        if (fh.size() < dep(i)) return rv(i);
        return fh[fh.size() - dep(i)];
    endfunction

    function automatic logic [7:0] o_q(input int i);
        case (i)
            0:       return q0;
            1:       return q1;
            default: return q2;
        endcase
    endfunction

    function automatic logic [15:0] o_word(input int i);
        case (i)
            0:       return w0;
            1:       return w1;
            default: return w2;
        endcase
    endfunction

    function automatic logic o_valid(input int i);
        case (i)
            0:       return v0;
            1:       return v1;
            default: return v2;
        endcase
    endfunction

    function automatic logic [31:0] o_cnt(input int i);
        case (i)
            0:       return 32'(c0);
            1:       return 32'(c1);
            default: return 32'(c2);
        endcase
    endfunction

    function automatic logic [7:0] rnd8();
        return 8'($urandom);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rh.delete();
        fh.delete();
        m_en_q   = 1'b0;
        m_mode_q = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_fill[i]  = 0;
            m_word[i]  = 16'h0;
            m_valid[i] = 1'b0;
            m_cnt[i]   = 0;
        end
    endtask

    task automatic model_pos(input logic en_v, input logic mode_v, input logic [7:0] dv);
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 1'b0;
            if (m_mode_q && m_en_q) begin
                m_word[i] = {f_last(i), r_last(i)};
                m_cnt[i]  = m_cnt[i] + 1;
                if (m_fill[i] < dep(i)) m_fill[i] = m_fill[i] + 1;
                m_valid[i] = (m_fill[i] >= dep(i));
            end
            if (mode_v != m_mode_q) begin
                m_fill[i]  = 0;
                m_valid[i] = 1'b0;
            end
        end
        if (en_v) rh.push_back(dv);
        m_en_q   = en_v;
        m_mode_q = mode_v;
    endtask

    task automatic model_neg(input logic [7:0] dv);
        if (m_mode_q && m_en_q) fh.push_back(dv);
    endtask

    task automatic check_hi(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.u%0d.word", tag, i), 32'(o_word(i)), 32'(m_word[i]));
            chk($sformatf("%s.u%0d.valid", tag, i), 32'(o_valid(i)), 32'(m_valid[i]));
            chk($sformatf("%s.u%0d.cnt", tag, i), o_cnt(i), m_cnt[i] & cnt_mask(i));
            chk($sformatf("%s.u%0d.q_hi", tag, i), 32'(o_q(i)), 32'(r_last(i)));
        end
    endtask

    task automatic check_lo(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.u%0d.q_lo", tag, i), 32'(o_q(i)),
                32'(m_mode_q ? f_last(i) : r_last(i)));
        end
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.u%0d.rst_q", tag, i), 32'(o_q(i)), 32'(rv(i)));
            chk($sformatf("%s.u%0d.rst_word", tag, i), 32'(o_word(i)), 32'h0);
            chk($sformatf("%s.u%0d.rst_valid", tag, i), 32'(o_valid(i)), 32'h0);
            chk($sformatf("%s.u%0d.rst_cnt", tag, i), o_cnt(i), 32'h0);
        end
    endtask

    // Entered and left in the low phase, 1 time unit after a negedge.
    task automatic step(input logic en_v, input logic mode_v, input logic [7:0] rd,
                        input logic [7:0] fd, input string tag);
        en       = en_v;
        ddr_mode = mode_v;
        d        = rd;
        @(posedge clk);
        model_pos(en_v, mode_v, rd);
        #1;
        d = fd;
        check_hi(tag);
        @(negedge clk);
        model_neg(fd);
        #1;
        check_lo(tag);
    endtask

    task automatic reset_now(input logic at_high, input string tag);
        if (at_high) @(posedge clk);
        else         @(negedge clk);
        #2;
        rst_n    = 1'b0;
        en       = 1'b0;
        ddr_mode = 1'b0;
        model_reset();
        #1;
        check_reset(tag);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] a1, a2, b1, b2;
        rst_n    = 1'b0;
        en       = 1'b0;
        ddr_mode = 1'b0;
        d        = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset("init");
        rst_n = 1'b1;

        // DDR, fixed data
        step(1'b0, 1'b1, 8'h00, 8'h00, "t2_arm");
        step(1'b1, 1'b1, 8'h11, 8'h22, "t2");
        step(1'b1, 1'b1, 8'h33, 8'h44, "t2");
        chk("t2.u0.word_first", 32'(w0), 32'h2211);
        chk("t2.u0.valid_first", 32'(v0), 32'h1);
        step(1'b0, 1'b1, 8'h55, 8'h66, "t2");
        chk("t2.u0.word_second", 32'(w0), 32'h4433);
        step(1'b0, 1'b1, 8'h77, 8'h88, "t2_idle");

        // en gap between two pairs, data toggling during the gap
        a1 = rnd8(); a2 = rnd8(); b1 = rnd8(); b2 = rnd8();
        step(1'b1, 1'b1, a1, a2, "t3_a");
        step(1'b0, 1'b1, rnd8(), rnd8(), "t3_gap");
        step(1'b0, 1'b1, rnd8(), rnd8(), "t3_gap");
        chk("t3.u0.word_a", 32'(w0), 32'({a2, a1}));
        step(1'b1, 1'b1, b1, b2, "t3_b");
        step(1'b0, 1'b1, rnd8(), rnd8(), "t3_tail");
        chk("t3.u0.word_b", 32'(w0), 32'({b2, b1}));
        step(1'b0, 1'b1, rnd8(), rnd8(), "t3_tail");

        // reset in the high phase with loaded pipes
        step(1'b1, 1'b1, rnd8(), rnd8(), "t1_load");
        reset_now(1'b1, "t1");

        // deeper pipe fill behaviour
        step(1'b0, 1'b1, rnd8(), rnd8(), "t4_arm");
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, rnd8(), rnd8(), "t4_pair");
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, rnd8(), rnd8(), "t4_drain");

        // SDR with data moving on both edges, then back to DDR
        for (int k = 0; k < 8; k++) step(1'($urandom_range(0, 1)), 1'b0, rnd8(), rnd8(), "t5_sdr");
        step(1'b1, 1'b1, rnd8(), rnd8(), "t5_sw");
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, rnd8(), rnd8(), "t5_ddr");
        step(1'b0, 1'b1, rnd8(), rnd8(), "t5_idle");

        // long random stream: counter wrap on the 4-bit instance, occasional mode flips
        for (int k = 0; k < 60; k++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) != 0),
                 rnd8(), rnd8(), "t6_rand");
        end
        for (int k = 0; k < 18; k++) step(1'b1, 1'b1, rnd8(), rnd8(), "t6_wrap");
        reset_now(1'b0, "t6_rst");
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, rnd8(), rnd8(), "t6_post");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
